// File: rtl/axis_iter_divider_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
// The state encoding and the divide-by-zero quotient are used by the top and the bench.
package div_pkg;

    localparam int DIV_W       = 32;
    localparam int DIV_ITERS   = 32;
    localparam int DIV_LATENCY = 34;

    localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/axis_iter_divider_if.sv
// Operand/result stream bundle between the EXE stage (master) and the divider (slave).
// The result side has no ready: the consumer must take dout in its valid cycle(s).
interface axis_iter_divider_if
    import div_pkg::*;
;
    logic [DIV_W-1:0]   s_axis_dividend_tdata;
    logic               s_axis_dividend_tvalid;
    logic               s_axis_dividend_tready;
    logic [DIV_W-1:0]   s_axis_divisor_tdata;
    logic               s_axis_divisor_tvalid;
    logic               s_axis_divisor_tready;
    logic [2*DIV_W-1:0] m_axis_dout_tdata;
    logic               m_axis_dout_tvalid;

    modport master (
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_divisor_tdata,  s_axis_divisor_tvalid,
        input  s_axis_dividend_tready, s_axis_divisor_tready,
        input  m_axis_dout_tdata, m_axis_dout_tvalid
    );

    modport slave (
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_divisor_tdata,  s_axis_divisor_tvalid,
        output s_axis_dividend_tready, s_axis_divisor_tready,
        output m_axis_dout_tdata, m_axis_dout_tvalid
    );

endinterface

// File: rtl/axis_iter_divider_restore_step.sv
// One combinational radix-2 restoring step on magnitudes: shift {rem, quo}, trial-subtract.
// rem_i is always below dvsr_i, so the 33-bit shifted remainder never overflows the compare.
module div_restore_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic [DIV_W-1:0] quo_i,
    input  logic [DIV_W-1:0] dvsr_i,
    output logic [DIV_W-1:0] rem_o,
    output logic [DIV_W-1:0] quo_o
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] diff;
    logic           fits;

    always_comb begin
        shifted = {rem_i, quo_i[DIV_W-1]};
        diff    = shifted - {1'b0, dvsr_i};
        fits    = (shifted >= {1'b0, dvsr_i});
        rem_o   = fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
        quo_o   = {quo_i[DIV_W-2:0], fits};
    end

endmodule

// File: rtl/axis_iter_divider.sv
// Radix-2 restoring 32-bit divider, 34-cycle fixed latency, one op per 35 cycles; no dout backpressure.
// Operands taken only as a pair in IDLE; AXIS_ITER_DIVIDER_HOLD_RESULT_EN holds tvalid until next accept/cancel.
module axis_iter_divider
    import div_pkg::*;
#(
    parameter bit SIGNED = 1'b1,
    parameter int DW     = 32
)
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                cancel,
    axis_iter_divider_if.slave  div_if
);

    if (DW != 32) begin : g_bad_dw
        $error("axis_iter_divider: only DW=32 is supported");
    end

    div_state_e         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [DIV_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [DIV_W-1:0]   dvsr_q, dvsr_d;
    logic [DIV_W-1:0]   dvnd_q, dvnd_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [2*DIV_W-1:0] res_q, res_d;
    logic               vld_q, vld_d;

    logic               accept;
    logic               rdy;
    logic               dout_vld;
    logic [DIV_W-1:0]   step_rem, step_quo;
    logic [DIV_W-1:0]   q_fix, r_fix;
    logic [DIV_W-1:0]   a_in, b_in;

    assign a_in   = div_if.s_axis_dividend_tdata;
    assign b_in   = div_if.s_axis_divisor_tdata;
    assign accept = (state_q == IDLE) & div_if.s_axis_dividend_tvalid
                  & div_if.s_axis_divisor_tvalid & ~cancel;

    div_restore_step u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (cancel) state_d = IDLE;
                     else if (cnt_q == 5'(DIV_ITERS - 1)) state_d = FIX;
            FIX:     state_d = cancel ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy      = resetn & accept;
        dout_vld = vld_q & ~cancel;
    end

    assign div_if.s_axis_dividend_tready = rdy;
    assign div_if.s_axis_divisor_tready  = rdy;
    assign div_if.m_axis_dout_tvalid     = dout_vld;
    assign div_if.m_axis_dout_tdata      = res_q;

    // Magnitude result corrected for sign; a zero divisor overrides both halves.
    always_comb begin
        q_fix = (sa_q ^ sb_q) ? (32'd0 - quo_q) : quo_q;
        r_fix = sa_q ? (32'd0 - rem_q) : rem_q;
        if (dvsr_q == '0) begin
            q_fix = DIV0_QUOTIENT;
            r_fix = dvnd_q;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        dvnd_d = dvnd_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        res_d  = res_q;
        if (accept) begin
            dvnd_d = a_in;
            sa_d   = SIGNED ? a_in[DIV_W-1] : 1'b0;
            sb_d   = SIGNED ? b_in[DIV_W-1] : 1'b0;
            quo_d  = sa_d ? (32'd0 - a_in) : a_in;
            dvsr_d = sb_d ? (32'd0 - b_in) : b_in;
            rem_d  = '0;
            cnt_d  = '0;
        end else if ((state_q == BUSY) && !cancel) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 5'd1;
        end
        if ((state_q == FIX) && !cancel) res_d = {q_fix, r_fix};
`ifdef AXIS_ITER_DIVIDER_HOLD_RESULT_EN
        if ((state_q == FIX) && !cancel) vld_d = 1'b1;
        else if (accept || cancel)       vld_d = 1'b0;
        else                             vld_d = vld_q;
`else
        vld_d = (state_q == FIX) && !cancel;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            dvnd_q <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            res_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            dvnd_q <= dvnd_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            res_q  <= res_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: tb/tb_axis_iter_divider.sv
// Directed bench driving a signed and an unsigned divider with identical operand streams.
module tb_axis_iter_divider;

`ifdef AXIS_ITER_DIVIDER_HOLD_RESULT_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] es;
        logic [63:0] eu;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic cancel = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl [10];

    axis_iter_divider_if if_s ();
    axis_iter_divider_if if_u ();

    axis_iter_divider #(.SIGNED(1'b1), .DW(32)) dut_s (
        .clk(clk), .resetn(resetn), .cancel(cancel), .div_if(if_s.slave));
    axis_iter_divider #(.SIGNED(1'b0), .DW(32)) dut_u (
        .clk(clk), .resetn(resetn), .cancel(cancel), .div_if(if_u.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic va, input logic vb);
        if_s.s_axis_dividend_tdata = a;  if_u.s_axis_dividend_tdata = a;
        if_s.s_axis_divisor_tdata  = b;  if_u.s_axis_divisor_tdata  = b;
        if_s.s_axis_dividend_tvalid = va; if_u.s_axis_dividend_tvalid = va;
        if_s.s_axis_divisor_tvalid  = vb; if_u.s_axis_divisor_tvalid  = vb;
    endtask

    function automatic logic [3:0] rdys();
        return {if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready,
                if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready};
    endfunction

    // Called inside the accept cycle with the pair already driven; returns in cycle 34.
    task automatic wait_result(input string nm, input logic [63:0] es, input logic [63:0] eu,
                               input bit kill);
        logic ev;
        chk({nm, "_rdy"}, 64'(rdys()), 64'hF);
        @(posedge clk); #1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 34 && kill) begin cancel = 1'b1; #1; end
            ev = (k == 34) && !kill;
            chk($sformatf("%s_vld_s_c%0d", nm, k), 64'(if_s.m_axis_dout_tvalid), 64'(ev));
            chk($sformatf("%s_vld_u_c%0d", nm, k), 64'(if_u.m_axis_dout_tvalid), 64'(ev));
            if (ev) begin
                chk({nm, "_dat_s"}, if_s.m_axis_dout_tdata, es);
                chk({nm, "_dat_u"}, if_u.m_axis_dout_tdata, eu);
            end
        end
        if (kill) begin @(posedge clk); #1; cancel = 1'b0; end
    endtask

    // Cycles after DONE: result held, tvalid per build; then a cancel pulse clears any hold.
    task automatic check_after(input string nm, input logic [63:0] es, input logic [63:0] eu,
                               input bit chk_dat, input bit exp_v);
        for (int k = 35; k <= 37; k++) begin
            @(negedge clk);
            chk($sformatf("%s_post_vld_c%0d", nm, k), 64'(if_s.m_axis_dout_tvalid | if_u.m_axis_dout_tvalid), 64'(exp_v));
            if (chk_dat) begin
                chk($sformatf("%s_post_dat_s_c%0d", nm, k), if_s.m_axis_dout_tdata, es);
                chk($sformatf("%s_post_dat_u_c%0d", nm, k), if_u.m_axis_dout_tdata, eu);
            end
        end
        cancel = 1'b1; #1;
        chk({nm, "_cancel_idle_vld"}, 64'(if_s.m_axis_dout_tvalid | if_u.m_axis_dout_tvalid), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
    endtask

    initial begin
        int seen;
        tbl[0] = '{32'd7,        32'd2,        {32'd3,        32'd1},        {32'd3,        32'd1}};
        tbl[1] = '{32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFD, 32'hFFFFFFFF}, {32'h7FFFFFFC, 32'd1}};
        tbl[2] = '{32'd7,        32'hFFFFFFFE, {32'hFFFFFFFD, 32'd1},        {32'd0,        32'd7}};
        tbl[3] = '{32'd5,        32'd0,        {32'hFFFFFFFF, 32'd5},        {32'hFFFFFFFF, 32'd5}};
        tbl[4] = '{32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},        {32'd0,        32'h80000000}};
        tbl[5] = '{32'd100,      32'hFFFFFFF9, {32'hFFFFFFF2, 32'd2},        {32'd0,        32'd100}};
        tbl[6] = '{32'hFFFFFF9C, 32'hFFFFFFF9, {32'd14,       32'hFFFFFFFE}, {32'd0,        32'hFFFFFF9C}};
        tbl[7] = '{32'hFFFFFFFF, 32'h10,       {32'd0,        32'hFFFFFFFF}, {32'h0FFFFFFF, 32'hF}};
        tbl[8] = '{32'h80000000, 32'd0,        {32'hFFFFFFFF, 32'h80000000}, {32'hFFFFFFFF, 32'h80000000}};
        tbl[9] = '{32'd0,        32'd3,        {32'd0,        32'd0},        {32'd0,        32'd0}};

        // Reset with a pair offered: nothing may be ready or valid.
        drive(32'd7, 32'd2, 1'b1, 1'b1);
        #2 resetn = 1'b0;
        #2;
        chk("rst_rdy", 64'(rdys()), 64'd0);
        chk("rst_vld", 64'(if_s.m_axis_dout_tvalid | if_u.m_axis_dout_tvalid), 64'd0);
        chk("rst_dat_s", if_s.m_axis_dout_tdata, 64'd0);
        chk("rst_dat_u", if_u.m_axis_dout_tdata, 64'd0);
        repeat (2) @(negedge clk);
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].b, 1'b1, 1'b1);
            #1;
            wait_result($sformatf("vec%0d", i), tbl[i].es, tbl[i].eu, 1'b0);
            check_after($sformatf("vec%0d", i), tbl[i].es, tbl[i].eu, 1'b1, HOLD);
        end

        // Back-to-back: second pair offered during DONE, accepted at cycle 35.
        @(negedge clk);
        drive(32'd100, 32'd7, 1'b1, 1'b1);
        #1;
        wait_result("b2b_first", {32'd14, 32'd2}, {32'd14, 32'd2}, 1'b0);
        drive(32'd9, 32'd3, 1'b1, 1'b1);
        #1;
        chk("b2b_done_rdy", 64'(rdys()), 64'd0);
        @(negedge clk); #1;
        wait_result("b2b_second", {32'd3, 32'd0}, {32'd3, 32'd0}, 1'b0);
        check_after("b2b_second", {32'd3, 32'd0}, {32'd3, 32'd0}, 1'b1, HOLD);

        // A lone dividend valid is never consumed.
        @(negedge clk);
        drive(32'd9, 32'd3, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("lone_rdy_c%0d", c), 64'(rdys()), 64'd0);
            @(negedge clk);
        end
        drive(32'd9, 32'd3, 1'b1, 1'b1);
        #1;
        wait_result("lone_then_pair", {32'd3, 32'd0}, {32'd3, 32'd0}, 1'b0);
        check_after("lone_then_pair", {32'd3, 32'd0}, {32'd3, 32'd0}, 1'b1, HOLD);

        // Cancel during BUSY at cycle 10, new pair accepted at cycle 11.
        @(negedge clk);
        drive(32'd100, 32'd7, 1'b1, 1'b1);
        #1;
        chk("cxl_busy_rdy0", 64'(rdys()), 64'hF);
        @(posedge clk); #1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("cxl_busy_vld_c%0d", k), 64'(if_s.m_axis_dout_tvalid | if_u.m_axis_dout_tvalid), 64'd0);
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        drive(32'd7, 32'd2, 1'b1, 1'b1);
        #1;
        wait_result("cxl_busy_next", {32'd3, 32'd1}, {32'd3, 32'd1}, 1'b0);
        check_after("cxl_busy_next", {32'd3, 32'd1}, {32'd3, 32'd1}, 1'b1, HOLD);

        // Cancel together with a valid pair in IDLE: cancel wins.
        @(negedge clk);
        drive(32'd100, 32'd7, 1'b1, 1'b1);
        cancel = 1'b1;
        #1;
        chk("cxl_idle_rdy", 64'(rdys()), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        #1;
        wait_result("cxl_idle_then", {32'd14, 32'd2}, {32'd14, 32'd2}, 1'b0);
        check_after("cxl_idle_then", {32'd14, 32'd2}, {32'd14, 32'd2}, 1'b1, HOLD);

        // Cancel in DONE suppresses the valid cycle.
        @(negedge clk);
        drive(32'd7, 32'd2, 1'b1, 1'b1);
        #1;
        wait_result("cxl_done", {32'd3, 32'd1}, {32'd3, 32'd1}, 1'b1);
        check_after("cxl_done", {32'd3, 32'd1}, {32'd3, 32'd1}, 1'b0, 1'b0);

        // Asynchronous reset at cycle 20 of an op clears outputs and kills the result.
        @(negedge clk);
        drive(32'd100, 32'd7, 1'b1, 1'b1);
        #1;
        chk("rst_mid_rdy0", 64'(rdys()), 64'hF);
        @(posedge clk); #1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        drive(32'd9, 32'd3, 1'b1, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_vld", 64'(if_s.m_axis_dout_tvalid | if_u.m_axis_dout_tvalid), 64'd0);
        chk("rst_mid_dat_s", if_s.m_axis_dout_tdata, 64'd0);
        chk("rst_mid_dat_u", if_u.m_axis_dout_tdata, 64'd0);
        chk("rst_mid_rdy", 64'(rdys()), 64'd0);
        repeat (2) @(negedge clk);
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_s.m_axis_dout_tvalid || if_u.m_axis_dout_tvalid ||
                if_s.m_axis_dout_tdata != 64'd0 || if_u.m_axis_dout_tdata != 64'd0) seen++;
        end
        chk("rst_mid_no_result", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
